// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester-side and UART-transmitter-side signals for uart_tx_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   i_Req;
    logic [8*NUM_REQ-1:0] i_Req_Byte;
    logic [NUM_REQ-1:0]   o_Ack;
    logic [3:0]           o_Grant_Id;
    logic                 o_Busy;
    logic                 o_Frame_Done;
    logic                 o_TX_DV;
    logic [7:0]           o_TX_Byte;
    logic                 i_TX_Active;
    logic                 i_TX_Done;

    modport slave (
        input  i_Req, i_Req_Byte, i_TX_Active, i_TX_Done,
        output o_Ack, o_Grant_Id, o_Busy, o_Frame_Done, o_TX_DV, o_TX_Byte
    );

    modport master (
        output i_Req, i_Req_Byte, i_TX_Active, i_TX_Done,
        input  o_Ack, o_Grant_Id, o_Busy, o_Frame_Done, o_TX_DV, o_TX_Byte
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one 8N1 UART transmitter between NUM_REQ byte sources,
// each frame being an optional tag byte {4'hA, id} followed by the source's data byte.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter bit TAG_EN  = 1'b1
) (
    input logic              i_Clock,
    input logic              i_Reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {ARB, LAUNCH, WAIT_ACTIVE, WAIT_DONE, WAIT_IDLE} state_t;
    typedef enum logic [1:0] {PH_NONE, PH_TAG, PH_DATA} phase_t;

    state_t             r_State;
    phase_t             r_Phase;
    logic [3:0]         r_Ptr;
    logic [7:0]         r_Data;
    logic [NUM_REQ-1:0] r_Ack;
    logic [3:0]         r_Grant_Id;
    logic               r_Busy;
    logic               r_Frame_Done;
    logic               r_TX_DV;
    logic [7:0]         r_TX_Byte;

    logic               w_Grant_Valid;
    logic [3:0]         w_Grant_Id;
    logic [7:0]         w_Grant_Byte;
    logic [IDX_W-1:0]   w_Idx;
    int                 w_Sum;

    // Search upward from the requester after the last granted one, wrapping once.
    always_comb begin
        w_Grant_Valid = 1'b0;
        w_Grant_Id    = '0;
        w_Grant_Byte  = '0;
        w_Idx         = '0;
        w_Sum         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_Sum = int'(r_Ptr) + 1 + k;
            if (w_Sum >= NUM_REQ) begin
                w_Sum = w_Sum - NUM_REQ;
            end
            w_Idx = IDX_W'(w_Sum);
            if (!w_Grant_Valid && bus.i_Req[w_Idx]) begin
                w_Grant_Valid = 1'b1;
                w_Grant_Id    = 4'(w_Sum);
                w_Grant_Byte  = bus.i_Req_Byte[{w_Idx, 3'b000} +: 8];
            end
        end
    end

    // Reset lands in WAIT_IDLE with no phase, since the transmitter itself is not reset.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_State      <= WAIT_IDLE;
            r_Phase      <= PH_NONE;
            r_Ptr        <= 4'(NUM_REQ - 1);
            r_Data       <= '0;
            r_Ack        <= '0;
            r_Grant_Id   <= '0;
            r_Busy       <= 1'b0;
            r_Frame_Done <= 1'b0;
            r_TX_DV      <= 1'b0;
            r_TX_Byte    <= '0;
        end else begin
            r_Ack        <= '0;
            r_Frame_Done <= 1'b0;
            r_TX_DV      <= 1'b0;
            case (r_State)
                ARB: begin
                    if (w_Grant_Valid) begin
                        r_Ack      <= NUM_REQ'(1) << w_Grant_Id;
                        r_Data     <= w_Grant_Byte;
                        r_Grant_Id <= w_Grant_Id;
                        r_Ptr      <= w_Grant_Id;
                        r_Busy     <= 1'b1;
                        r_Phase    <= TAG_EN ? PH_TAG : PH_DATA;
                        r_State    <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    r_TX_Byte <= (r_Phase == PH_TAG) ? {4'hA, r_Grant_Id} : r_Data;
                    r_TX_DV   <= 1'b1;
                    r_State   <= WAIT_ACTIVE;
                end
                WAIT_ACTIVE: begin
                    if (bus.i_TX_Active) begin
                        r_State <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (bus.i_TX_Done) begin
                        r_State <= WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    // Done may linger; only both-low proves the transmitter will sample DV.
                    if (!bus.i_TX_Active && !bus.i_TX_Done) begin
                        case (r_Phase)
                            PH_TAG: begin
                                r_Phase <= PH_DATA;
                                r_State <= LAUNCH;
                            end
                            PH_DATA: begin
                                r_Frame_Done <= 1'b1;
                                r_Busy       <= 1'b0;
                                r_Phase      <= PH_NONE;
                                r_State      <= ARB;
                            end
                            default: begin
                                r_State <= ARB;
                            end
                        endcase
                    end
                end
                default: begin
                    r_State <= ARB;
                end
            endcase
        end
    end

    assign bus.o_Ack        = r_Ack;
    assign bus.o_Grant_Id   = r_Grant_Id;
    assign bus.o_Busy       = r_Busy;
    assign bus.o_Frame_Done = r_Frame_Done;
    assign bus.o_TX_DV      = r_TX_DV;
    assign bus.o_TX_Byte    = r_TX_Byte;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a tagged instance behind a behavioural UART
// transmitter, plus an untagged instance whose transmitter handshake is driven by hand.
module tb_uart_tx_arbiter;
    localparam int NUM_REQ    = 4;
    localparam int ACTIVE_LEN = 4;

    logic clock = 1'b0;
    logic reset;

    int checkCount = 0;
    int passCount  = 0;
    int frameCount = 0;
    int dvCount    = 0;
    int dv0Count   = 0;
    int doneLen    = 1;

    int         ackLimit[$];
    int         ackCount[$];
    logic [7:0] expByteQ[$];
    int         expGrantQ[$];

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();
    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus0 ();

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .TAG_EN(1'b1)) dut (
        .i_Clock (clock),
        .i_Reset (reset),
        .bus     (bus)
    );

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .TAG_EN(1'b0)) dutNoTag (
        .i_Clock (clock),
        .i_Reset (reset),
        .bus     (bus0)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int id, input logic [7:0] data, input int count);
        logic [31:0] bytesNow;
        bytesNow = bus.i_Req_Byte;
        bytesNow = (bytesNow & ~(32'hFF << (8 * id))) | (32'(data) << (8 * id));
        bus.i_Req_Byte = bytesNow;
        ackLimit[id] = ackLimit[id] + count;
    endtask

    task automatic expectFrame(input int id, input logic [7:0] data);
        expGrantQ.push_back(id);
        expByteQ.push_back({4'hA, 4'(id)});
        expByteQ.push_back(data);
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic checkIdleOutputs(input string pfx);
        checkOutput({pfx, "Ack"},       32'(bus.o_Ack), 0);
        checkOutput({pfx, "GrantId"},   32'(bus.o_Grant_Id), 0);
        checkOutput({pfx, "Busy"},      32'(bus.o_Busy), 0);
        checkOutput({pfx, "FrameDone"}, 32'(bus.o_Frame_Done), 0);
        checkOutput({pfx, "TxDv"},      32'(bus.o_TX_DV), 0);
        checkOutput({pfx, "TxByte"},    32'(bus.o_TX_Byte), 0);
    endtask

    task automatic waitFrames(input int target, input string tag);
        int cyc = 0;
        while (frameCount < target && cyc < 400) begin
            @(negedge clock);
            cyc++;
        end
        checkOutput(tag, 32'(frameCount), 32'(target));
    endtask

    task automatic waitDv(input int target, input string tag);
        int cyc = 0;
        while (dvCount < target && cyc < 400) begin
            @(negedge clock);
            cyc++;
        end
        checkOutput(tag, 32'(dvCount), 32'(target));
    endtask

    task automatic serveNoTag(input int id, input logic [7:0] expByte);
        int cyc = 0;
        while (bus0.o_Ack === '0 && cyc < 50) begin
            @(negedge clock);
            cyc++;
        end
        checkOutput("noTagAck", 32'(bus0.o_Ack), 32'(1) << id);
        checkOutput("noTagGrantId", 32'(bus0.o_Grant_Id), 32'(id));
        bus0.i_Req = bus0.i_Req & ~(4'd1 << id);
        cyc = 0;
        while (bus0.o_TX_DV !== 1'b1 && cyc < 50) begin
            @(negedge clock);
            cyc++;
        end
        checkOutput("noTagByte", 32'(bus0.o_TX_Byte), 32'(expByte));
        bus0.i_TX_Active = 1'b1;
        repeat (3) @(negedge clock);
        bus0.i_TX_Active = 1'b0;
        bus0.i_TX_Done   = 1'b1;
        @(negedge clock);
        bus0.i_TX_Done   = 1'b0;
        cyc = 0;
        while (bus0.o_Frame_Done !== 1'b1 && cyc < 50) begin
            @(negedge clock);
            cyc++;
        end
        checkOutput("noTagFrameDone", 32'(bus0.o_Frame_Done), 1);
    endtask

    // Requester agent: holds each request until its quota of acks is used up, and scores grants.
    initial begin
        int g;
        logic [3:0] reqNext;
        ackCount = '{0, 0, 0, 0};
        bus.i_Req = '0;
        forever begin
            @(negedge clock);
            if (|bus.o_Ack === 1'b1) begin
                if (expGrantQ.size() == 0) begin
                    checkOutput("unexpectedAck", 32'(bus.o_Ack), 0);
                end else begin
                    g = expGrantQ.pop_front();
                    checkOutput("ackVec", 32'(bus.o_Ack), 32'(1) << g);
                    checkOutput("grantId", 32'(bus.o_Grant_Id), 32'(g));
                    checkOutput("busyAtAck", 32'(bus.o_Busy), 1);
                end
                for (int n = 0; n < NUM_REQ; n++) begin
                    if (((bus.o_Ack >> n) & 4'd1) != 4'd0) begin
                        ackCount[n] = ackCount[n] + 1;
                    end
                end
            end
            if (bus.o_Frame_Done === 1'b1) begin
                frameCount++;
                checkOutput("busyAtDone", 32'(bus.o_Busy), 0);
            end
            reqNext = '0;
            for (int n = 0; n < NUM_REQ; n++) begin
                if (ackCount[n] < ackLimit[n]) begin
                    reqNext = reqNext | (4'd1 << n);
                end
            end
            bus.i_Req = reqNext;
        end
    end

    // Behavioural UART transmitter: not reset, so it keeps transmitting across a DUT reset.
    initial begin
        int activeLeft = 0;
        int doneLeft   = 0;
        bus.i_TX_Active = 1'b0;
        bus.i_TX_Done   = 1'b0;
        forever begin
            @(negedge clock);
            if (bus.o_TX_DV === 1'b1) begin
                dvCount++;
                checkOutput("dvWhileBusy", 32'({bus.i_TX_Active, bus.i_TX_Done}), 0);
                if (expByteQ.size() == 0) begin
                    checkOutput("unexpectedDv", 32'(expByteQ.size()), 1);
                end else begin
                    checkOutput("txByte", 32'(bus.o_TX_Byte), 32'(expByteQ.pop_front()));
                end
                bus.i_TX_Active = 1'b1;
                bus.i_TX_Done   = 1'b0;
                activeLeft      = ACTIVE_LEN;
                doneLeft        = 0;
            end else if (activeLeft > 0) begin
                activeLeft--;
                if (activeLeft == 0) begin
                    bus.i_TX_Active = 1'b0;
                    bus.i_TX_Done   = 1'b1;
                    doneLeft        = doneLen;
                end
            end else if (doneLeft > 0) begin
                doneLeft--;
                if (doneLeft == 0) begin
                    bus.i_TX_Done = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (bus0.o_TX_DV === 1'b1) begin
                dv0Count++;
            end
        end
    end

    initial begin
        int baseFrames;
        int baseDv;
        int cyc;
        logic earlyAck;

        ackLimit          = '{0, 0, 0, 0};
        bus.i_Req_Byte    = '0;
        bus0.i_Req        = '0;
        bus0.i_Req_Byte   = '0;
        bus0.i_TX_Active  = 1'b0;
        bus0.i_TX_Done    = 1'b0;
        reset             = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        checkIdleOutputs("rst");

        $display("[TB] single request with tag");
        expectFrame(2, 8'h5A);
        applyStimulus(2, 8'h5A, 1);
        waitFrames(1, "singleFrames");
        repeat (2) @(negedge clock);
        checkOutput("singleBusy", 32'(bus.o_Busy), 0);
        checkOutput("singleQueue", 32'(expByteQ.size()), 0);

        $display("[TB] round robin over four held requesters");
        pulseReset();
        baseFrames = frameCount;
        for (int i = 0; i < 5; i++) begin
            expectFrame(i % 4, 8'((i % 4 + 1) * 17));
        end
        for (int n = 0; n < NUM_REQ; n++) begin
            applyStimulus(n, 8'((n + 1) * 17), (n == 0) ? 2 : 1);
        end
        waitFrames(baseFrames + 5, "rrFrames");
        repeat (2) @(negedge clock);
        checkOutput("rrQueue", 32'(expGrantQ.size() + expByteQ.size()), 0);

        $display("[TB] request arriving mid-frame");
        baseFrames = frameCount;
        baseDv     = dvCount;
        expectFrame(2, 8'h77);
        expectFrame(0, 8'h99);
        applyStimulus(2, 8'h77, 1);
        waitDv(baseDv + 2, "midDataDv");
        applyStimulus(0, 8'h99, 1);
        earlyAck = 1'b0;
        cyc = 0;
        while (frameCount < baseFrames + 1 && cyc < 200) begin
            @(negedge clock);
            cyc++;
            if (bus.o_Ack[0] === 1'b1 && frameCount < baseFrames + 1) begin
                earlyAck = 1'b1;
            end
        end
        checkOutput("midEarlyAck", 32'(earlyAck), 0);
        waitFrames(baseFrames + 2, "midFrames");
        repeat (2) @(negedge clock);

        $display("[TB] reset while transmitter is mid-byte");
        baseDv = dvCount;
        expGrantQ.push_back(1);
        expByteQ.push_back(8'hA1);
        applyStimulus(1, 8'h5C, 1);
        waitDv(baseDv + 1, "abortTagDv");
        repeat (2) @(negedge clock);
        baseFrames = frameCount;
        expectFrame(0, 8'h3C);
        applyStimulus(0, 8'h3C, 1);
        pulseReset();
        checkIdleOutputs("abort");
        waitFrames(baseFrames + 1, "abortRecover");
        repeat (5) @(negedge clock);
        checkOutput("abortFrames", 32'(frameCount), 32'(baseFrames + 1));
        checkOutput("abortQueue", 32'(expGrantQ.size() + expByteQ.size()), 0);

        $display("[TB] long transmitter done");
        doneLen    = 2;
        baseFrames = frameCount;
        expectFrame(3, 8'hE1);
        applyStimulus(3, 8'hE1, 1);
        waitFrames(baseFrames + 1, "longDoneFrames");
        repeat (3) @(negedge clock);
        doneLen = 1;
        checkOutput("longDoneQueue", 32'(expByteQ.size()), 0);

        $display("[TB] untagged instance, requesters 1 and 3");
        bus0.i_Req_Byte = 32'h44332211;
        bus0.i_Req      = 4'b1010;
        serveNoTag(1, 8'h22);
        serveNoTag(3, 8'h44);
        repeat (20) @(negedge clock);
        checkOutput("noTagDvCount", 32'(dv0Count), 2);
        checkOutput("noTagBusy", 32'(bus0.o_Busy), 0);

        checkOutput("grantQueueEmpty", 32'(expGrantQ.size()), 0);
        checkOutput("byteQueueEmpty", 32'(expByteQ.size()), 0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter (8N1, byte-wide i_TX_DV/i_TX_Byte input, o_TX_Active/o_TX_Done status) between NUM_REQ byte sources.
- Round-robin arbitration per frame. A frame is an optional tag byte identifying the source, followed by the source's data byte.
- Sits between the requesters and the UART transmitter, and sequences the transmitter's DV/Done handshake.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- TAG_EN, 1, 1 = send tag byte {4'hA, id[3:0]} before each data byte; 0 = data byte only.

Ports:
- i_Clock  input  1  system clock; all logic on posedge.
- i_Reset  input  1  synchronous, active-high reset.
- i_Req  input  NUM_REQ  per-requester request; level, held until acked.
- i_Req_Byte  input  8*NUM_REQ  data bytes; requester n uses bits [8n+7:8n].
- o_Ack  output  NUM_REQ  one-cycle pulse when requester's byte is latched.
- o_Grant_Id  output  4  id of the frame currently owning the transmitter.
- o_Busy  output  1  high from grant until the frame's last byte completes.
- o_Frame_Done  output  1  one-cycle pulse when the frame's last byte finishes.
- o_TX_DV  output  1  one-cycle launch strobe to the UART transmitter.
- o_TX_Byte  output  8  byte to the UART transmitter; stable from the DV cycle until the next launch.
- i_TX_Active  input  1  UART transmitter busy status.
- i_TX_Done  input  1  UART transmitter done status (may be high for more than one cycle).

Behaviour:
Reset:
- Clock is i_Clock. i_Reset is synchronous, active-high.
- On reset: o_Ack=0, o_Grant_Id=0, o_Busy=0, o_Frame_Done=0, o_TX_DV=0, o_TX_Byte=0.
- Round-robin pointer (last granted) = NUM_REQ-1, so requester 0 has first priority.
- Reset state is WAIT_IDLE, not ARB, because the transmitter has no reset and may be mid-byte.
- Reset mid-frame aborts the frame. No Ack or Frame_Done is issued for it.

State machine:
- ARB:
  - If any i_Req is high, grant the first set bit searching from pointer+1 upward, wrapping modulo NUM_REQ.
  - Same cycle: latch i_Req_Byte[g], pulse o_Ack[g], set o_Grant_Id=g, set o_Busy=1, pointer<=g.
  - Go to LAUNCH with phase=TAG if TAG_EN, else phase=DATA.
  - If no request, stay in ARB.
- LAUNCH:
  - Drive o_TX_Byte = tag or latched data according to phase.
  - Pulse o_TX_DV for exactly one cycle.
  - Go to WAIT_ACTIVE.
- WAIT_ACTIVE: wait for i_TX_Active=1, then go to WAIT_DONE.
- WAIT_DONE: wait for i_TX_Done=1, then go to WAIT_IDLE.
- WAIT_IDLE: wait until i_TX_Active=0 and i_TX_Done=0 in the same cycle; this guarantees the transmitter is back in idle and samples DV. Then:
  - phase=TAG: set phase=DATA and go to LAUNCH.
  - phase=DATA (frame end): pulse o_Frame_Done, clear o_Busy, go to ARB.
  - Arriving from reset: go to ARB with no pulse.

Rules:
- At most one o_Ack bit is high in any cycle.
- Exactly one o_TX_DV pulse per byte. DV is never issued while i_TX_Active or i_TX_Done is high.
- Requests arriving mid-frame wait. Arbitration happens only in ARB, so a frame is never interleaved with another.
- A requester dropping i_Req before its Ack forfeits; no byte is sent.
- A requester re-asserting immediately after its Ack is granted again only if no other request is pending. Fairness: worst-case wait is NUM_REQ-1 frames.
- Minimum gap between consecutive frames: one ARB cycle plus one LAUNCH cycle.
- o_Grant_Id holds its last value while in ARB with no requests.
- Tag byte uses id[3:0] zero-extended; values above NUM_REQ-1 never appear.

Test Plan:
- Single request, TAG_EN=1: i_Req=4'b0100, byte 8'h5A. Expect o_Ack[2] pulse, tag 8'hA2 then 8'h5A on o_TX_Byte, two DV pulses, one o_Frame_Done after the second byte's Done falls, o_Busy=0 after.
- Round-robin: all four requesters held with bytes 11/22/33/44 and re-asserted after each Ack. Grant order 0,1,2,3,0; each requester acked exactly once per four frames.
- TAG_EN=0, requesters 1 and 3 both requesting. Grants 1 then 3; only bytes 8'h22, 8'h44 are sent, one DV each.
- Mid-frame request: requester 0 asserts while requester 2's data byte is transmitting. No Ack until requester 2's o_Frame_Done; then requester 0 is granted (pointer=2, search 3,0). Serial stream of requester 2 is not disturbed.
- Reset during WAIT_DONE with the transmitter mid-byte. All outputs 0 next cycle; no DV until i_TX_Active and i_TX_Done are both low; then requester 0 wins if requesting.
- Long Done: i_TX_Done held high 2 cycles after each byte. Exactly one DV per byte; next DV only after Done is low.
